chaos_bit_packer: RTL and testbench
===================================

// Module: chaos_bit_packer
// PURPOSE
//   Downstream of the Q8.8 chaotic-value comparator: samples its 1-bit output on a strobe and
//   optionally removes bias with a von Neumann corrector. Packs accepted bits MSB-first into
//   WORD_W-bit words and delivers them over valid/ready to the LFSR seed/reseed logic.
//   Holds one word in the shift register and one in the output register.
// PARAMETERS
//   WORD_W   16  packed word width; legal range 2..32
//   DEBIAS   1   1 = von Neumann pair correction on; 0 = every strobed bit is accepted
//   CNT_W    16  width of the discard counter
// PORTS
//   clk          in   1       single clock; all state updates on rising edge
//   rst          in   1       synchronous, active-high reset
//   bit_valid    in   1       strobe: chaos_bit is sampled this cycle
//   chaos_bit    in   1       comparator output (chaotic > ref)
//   word_out     out  WORD_W  packed word; first accepted bit is the MSB
//   word_valid   out  1       word_out holds an undelivered word
//   word_ready   in   1       consumer accepts word_out this cycle when word_valid=1
//   overflow     out  1       sticky: an accepted bit was dropped because both stores were full
//   discard_cnt  out  CNT_W   saturating count of discarded equal pairs (00/11)
// BEHAVIOUR
//   Reset: word_out=0, word_valid=0, overflow=0, discard_cnt=0. Shift register and bit count=0.
//     Pair FSM=P_IDLE. Mid-operation reset discards any held half-pair, partial word, full
//     word and output word.
//   Pair FSM (DEBIAS=1), advances only on bit_valid:
//     P_IDLE  + bit_valid: store b0 -> P_FIRST.
//     P_FIRST + bit_valid with b1: if b0!=b1, accept bit b0 (01->0, 10->1); if b0==b1, discard.
//       On discard, discard_cnt increments, saturating at all-ones. Either way -> P_IDLE.
//     bit_valid=0 holds the FSM; gaps between the two bits of a pair are allowed.
//   DEBIAS=0: the pair FSM is bypassed; each bit_valid accepts chaos_bit; discard_cnt stays 0.
//   Packing: an accepted bit shifts in as sreg <= {sreg[WORD_W-2:0], bit}; count increments.
//   Word complete: the accepted bit that makes count==WORD_W completes the word.
//     Output register free (word_valid=0, or word_valid&word_ready this cycle):
//       the completed word loads word_out in the same edge; word_valid=1 from the next cycle.
//       count -> 0.
//     Output register not free: the completed word stays in sreg; count stays WORD_W (FULL).
//   FULL: further accepted bits are dropped and overflow is set. The pair FSM keeps running.
//     On word_valid&word_ready, sreg moves to word_out and count -> 0.
//     If a bit is accepted in that same cycle, it becomes the first bit of the next word
//       (count=1) and is not dropped.
//   Handshake: the transfer occurs on the edge where word_valid&word_ready=1. word_out is
//     stable while word_valid=1 and word_ready=0. word_valid falls after a transfer unless
//     a new word loads in the same edge.
//   Latency: last accepted bit's edge -> word_valid=1 the next cycle (1 cycle), when the
//     output register is free.
//   overflow is cleared only by rst. Words are delivered strictly in completion order.
// TESTING
//   1 DEBIAS=1: 16 pairs alternating (0,1),(1,0), bit_valid=1 every cycle, word_ready=1
//     -> word_out=16'h5555, word_valid=1 for one cycle, 1 cycle after 32nd strobe.
//   2 DEBIAS=1: 8 pairs (0,0),(1,1) -> discard_cnt=8, word_valid stays 0.
//     Then 2^CNT_W+5 equal pairs -> discard_cnt saturates at all-ones.
//   3 word_ready=0; feed 48 accepted bits (words A=16'hFFFF, B=16'h0000, C)
//     -> word_out=A, sreg holds B, C's bits dropped, overflow=1.
//     Then ready=1 -> A, then B, delivered on consecutive handshakes; overflow stays 1.
//   4 Same stimulus as test 1 with bit_valid every 3rd cycle and random gaps inside pairs
//     -> identical word 16'h5555; nothing accepted on bit_valid=0 cycles.
//   5 Reset mid-operation: hold a first bit (P_FIRST) with 7 bits packed, pulse rst
//     -> all outputs 0; the next 32 strobes of test-1 pattern yield 16'h5555
//     (no stale bits).
//   6 DEBIAS=0: bits 1011_0000_0000_1111 -> word_out=16'hB00F.
//     A FULL-state handshake coincident with an accepted bit -> the bit is the MSB of the
//     next word, overflow unchanged.

Source files
------------

// File: rtl/chaos_bit_packer.sv
// Chaotic-bit packer.
// Takes the 1-bit output of the chaotic-value comparator when bit_valid is high.
// When DEBIAS=1, a von Neumann pair corrector first removes bias from the bits.
// Accepted bits are packed MSB-first into WORD_W-bit words.
// Finished words go to the LFSR seed logic over a valid/ready handshake.
// One word can wait in the shift register while another sits in the output register.
//
// Ports:
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous active-high reset
//   bit_valid    in   1       chaos_bit is sampled this cycle
//   chaos_bit    in   1       comparator output
//   word_out     out  WORD_W  packed word, first accepted bit in the MSB
//   word_valid   out  1       word_out holds an undelivered word
//   word_ready   in   1       consumer takes word_out when word_valid=1
//   overflow     out  1       sticky: an accepted bit was dropped (both stores full)
//   discard_cnt  out  CNT_W   saturating count of discarded equal pairs
module chaos_bit_packer #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned DEBIAS = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_valid,
    input  logic              chaos_bit,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              overflow,
    output logic [CNT_W-1:0]  discard_cnt
);

    localparam int unsigned CW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] C_FULL = CW'(WORD_W);

    typedef enum logic {P_IDLE = 1'b0, P_FIRST = 1'b1} pair_state_t;

    pair_state_t       r_state;
    pair_state_t       w_state_nxt;
    logic              r_b0;
    logic              w_acc;
    logic              w_acc_bit;
    logic              w_disc;

    logic [WORD_W-1:0] r_sreg;
    logic [CW-1:0]     r_cnt;
    logic [WORD_W-1:0] r_word;
    logic              r_word_valid;
    logic              r_overflow;
    logic [CNT_W-1:0]  r_disc;

    logic [WORD_W-1:0] w_sreg_shift;
    logic [CW-1:0]     w_cnt_inc;
    logic              w_full;
    logic              w_xfer;
    logic              w_out_free;

    // Pair FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= P_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Pair FSM next state: moves only on strobes, so gaps inside a pair are allowed
    always_comb begin
        w_state_nxt = r_state;
        if (bit_valid) begin
            case (r_state)
                P_IDLE:  w_state_nxt = P_FIRST;
                P_FIRST: w_state_nxt = P_IDLE;
                default: w_state_nxt = P_IDLE;
            endcase
        end
    end

    // Pair FSM outputs: decide whether to accept or discard; bypassed when DEBIAS=0
    always_comb begin
        w_acc     = 1'b0;
        w_acc_bit = 1'b0;
        w_disc    = 1'b0;
        if (DEBIAS == 0) begin
            w_acc     = bit_valid;
            w_acc_bit = chaos_bit;
        end else if (r_state == P_FIRST && bit_valid) begin
            if (r_b0 != chaos_bit) begin
                w_acc     = 1'b1;
                w_acc_bit = r_b0;
            end else begin
                w_disc = 1'b1;
            end
        end
    end

    // First bit of the pair, held until its partner arrives
    always_ff @(posedge clk) begin
        if (rst)                               r_b0 <= 1'b0;
        else if (r_state == P_IDLE && bit_valid) r_b0 <= chaos_bit;
    end

    assign w_sreg_shift = {r_sreg[WORD_W-2:0], w_acc_bit};
    assign w_cnt_inc    = r_cnt + CW'(1);
    assign w_full       = (r_cnt == C_FULL);
    assign w_xfer       = r_word_valid & word_ready;
    assign w_out_free   = ~r_word_valid | word_ready;

    // Packing, word hand-off and overflow/discard bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg       <= '0;
            r_cnt        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_disc       <= '0;
        end else begin
            // A transfer empties the output register unless a load below refills it
            if (w_xfer) r_word_valid <= 1'b0;

            if (w_full) begin
                if (w_xfer) begin
                    r_word       <= r_sreg;
                    r_word_valid <= 1'b1;
                    // A bit accepted in the same cycle starts the next word
                    if (w_acc) begin
                        r_sreg <= w_sreg_shift;
                        r_cnt  <= CW'(1);
                    end else begin
                        r_cnt  <= '0;
                    end
                end else if (w_acc) begin
                    r_overflow <= 1'b1;
                end
            end else if (w_acc) begin
                r_sreg <= w_sreg_shift;
                if (w_cnt_inc == C_FULL && w_out_free) begin
                    r_word       <= w_sreg_shift;
                    r_word_valid <= 1'b1;
                    r_cnt        <= '0;
                end else begin
                    // If the word completed here, count parks at WORD_W (full)
                    r_cnt <= w_cnt_inc;
                end
            end

            if (w_disc && r_disc != '1) r_disc <= r_disc + CNT_W'(1);
        end
    end

    assign word_out    = r_word;
    assign word_valid  = r_word_valid;
    assign overflow    = r_overflow;
    assign discard_cnt = r_disc;

endmodule

// File: tb/tb_chaos_bit_packer.sv
// Directed bench for chaos_bit_packer.
// dut0: debiased, with a narrow discard counter so saturation can be reached quickly.
// dut1: debias off.
module tb_chaos_bit_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_valid;
    logic        chaos_bit;
    logic        word_ready;

    logic [15:0] d0_word;
    logic        d0_valid;
    logic        d0_ovf;
    logic [3:0]  d0_disc;
    logic [15:0] d1_word;
    logic        d1_valid;
    logic        d1_ovf;
    logic [15:0] d1_disc;

    int n_tests = 0;
    int n_fail  = 0;
    int valid_cycles = 0;

    always #5 clk = ~clk;

    chaos_bit_packer #(.WORD_W(16), .DEBIAS(1), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .chaos_bit(chaos_bit),
        .word_out(d0_word), .word_valid(d0_valid), .word_ready(word_ready),
        .overflow(d0_ovf), .discard_cnt(d0_disc)
    );

    chaos_bit_packer #(.WORD_W(16), .DEBIAS(0), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .chaos_bit(chaos_bit),
        .word_out(d1_word), .word_valid(d1_valid), .word_ready(word_ready),
        .overflow(d1_ovf), .discard_cnt(d1_disc)
    );

    // Counts cycles with dut0 word_valid high, sampled away from the active edge
    always @(negedge clk) if (d0_valid) valid_cycles++;

    task automatic strobe(input logic b);
        bit_valid = 1'b1;
        chaos_bit = b;
        @(posedge clk); #1;
        bit_valid = 1'b0;
    endtask

    // Idle cycles with a toggling chaos_bit that must be ignored
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            bit_valid = 1'b0;
            chaos_bit = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bit_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Pairs (0,1),(1,0) repeated: gives accepted bits 0,1,0,1...
    task automatic pattern(input int npairs, input bit gaps);
        for (int i = 0; i < npairs; i++) begin
            logic b0;
            b0 = (i % 2) == 1;
            if (gaps && i != 0) idle(2);
            strobe(b0);
            if (gaps) idle(2 + 3 * int'($urandom_range(0, 1)));
            strobe(~b0);
        end
    endtask

    // Accepted bit via an unequal pair
    task automatic acc_bit(input logic b);
        strobe(b);
        strobe(~b);
    endtask

    task automatic test_reset();
        do_reset();
        if ({d0_word, d0_valid, d0_ovf, d0_disc} !== 22'h0) begin
            $display("FAIL reset_dut0: got %h required 0", {d0_word, d0_valid, d0_ovf, d0_disc});
            n_fail++;
        end
        n_tests++;
        if ({d1_word, d1_valid, d1_ovf, d1_disc} !== 34'h0) begin
            $display("FAIL reset_dut1: got %h required 0", {d1_word, d1_valid, d1_ovf, d1_disc});
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_alternating();
        do_reset();
        word_ready = 1'b1;
        valid_cycles = 0;
        pattern(15, 1'b0);
        strobe(1'b1);
        if (d0_valid !== 1'b0) begin
            $display("FAIL alt_early_valid: got %b required 0", d0_valid);
            n_fail++;
        end
        n_tests++;
        strobe(1'b0);
        if (d0_valid !== 1'b1 || d0_word !== 16'h5555) begin
            $display("FAIL alt_word: got valid=%b word=%h required 1/5555", d0_valid, d0_word);
            n_fail++;
        end
        n_tests++;
        idle(2);
        if (valid_cycles !== 1 || d0_valid !== 1'b0) begin
            $display("FAIL alt_valid_len: got %0d cycles valid=%b required 1/0", valid_cycles, d0_valid);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_discard();
        do_reset();
        word_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            strobe(1'(i % 2));
            strobe(1'(i % 2));
        end
        if (d0_disc !== 4'd8 || d0_valid !== 1'b0) begin
            $display("FAIL discard_8: got cnt=%0d valid=%b required 8/0", d0_disc, d0_valid);
            n_fail++;
        end
        n_tests++;
        for (int i = 0; i < 21; i++) begin
            strobe(1'b1);
            strobe(1'b1);
        end
        if (d0_disc !== 4'hF) begin
            $display("FAIL discard_sat: got %h required F", d0_disc);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_overflow();
        do_reset();
        word_ready = 1'b0;
        for (int i = 0; i < 16; i++) acc_bit(1'b1);
        for (int i = 0; i < 16; i++) acc_bit(1'b0);
        if (d0_word !== 16'hFFFF || d0_valid !== 1'b1 || d0_ovf !== 1'b0) begin
            $display("FAIL ovf_two_words: got word=%h valid=%b ovf=%b required FFFF/1/0", d0_word, d0_valid, d0_ovf);
            n_fail++;
        end
        n_tests++;
        for (int i = 0; i < 16; i++) acc_bit(1'b1);
        if (d0_word !== 16'hFFFF || d0_ovf !== 1'b1) begin
            $display("FAIL ovf_set: got word=%h ovf=%b required FFFF/1", d0_word, d0_ovf);
            n_fail++;
        end
        n_tests++;
        word_ready = 1'b1;
        idle(1);
        if (d0_word !== 16'h0000 || d0_valid !== 1'b1) begin
            $display("FAIL ovf_second: got word=%h valid=%b required 0000/1", d0_word, d0_valid);
            n_fail++;
        end
        n_tests++;
        idle(1);
        if (d0_valid !== 1'b0 || d0_ovf !== 1'b1) begin
            $display("FAIL ovf_drain: got valid=%b ovf=%b required 0/1", d0_valid, d0_ovf);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_gaps();
        do_reset();
        word_ready = 1'b1;
        valid_cycles = 0;
        pattern(16, 1'b1);
        if (d0_valid !== 1'b1 || d0_word !== 16'h5555 || d0_disc !== 4'd0) begin
            $display("FAIL gaps_word: got valid=%b word=%h disc=%0d required 1/5555/0", d0_valid, d0_word, d0_disc);
            n_fail++;
        end
        n_tests++;
        idle(1);
        if (valid_cycles !== 1) begin
            $display("FAIL gaps_valid_len: got %0d required 1", valid_cycles);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        word_ready = 1'b1;
        pattern(7, 1'b0);
        strobe(1'b1);
        do_reset();
        if ({d0_word, d0_valid, d0_ovf, d0_disc} !== 22'h0) begin
            $display("FAIL midrst_outputs: got %h required 0", {d0_word, d0_valid, d0_ovf, d0_disc});
            n_fail++;
        end
        n_tests++;
        pattern(16, 1'b0);
        if (d0_valid !== 1'b1 || d0_word !== 16'h5555) begin
            $display("FAIL midrst_word: got valid=%b word=%h required 1/5555", d0_valid, d0_word);
            n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_no_debias();
        logic [15:0] v;
        do_reset();
        word_ready = 1'b1;
        v = 16'hB00F;
        for (int i = 15; i >= 0; i--) strobe(v[i]);
        if (d1_valid !== 1'b1 || d1_word !== 16'hB00F || d1_disc !== 16'd0) begin
            $display("FAIL nodeb_word: got valid=%b word=%h disc=%0d required 1/B00F/0", d1_valid, d1_word, d1_disc);
            n_fail++;
        end
        n_tests++;
        idle(1);
        word_ready = 1'b0;
        v = 16'h1234;
        for (int i = 15; i >= 0; i--) strobe(v[i]);
        if (d1_word !== 16'h1234 || d1_valid !== 1'b1) begin
            $display("FAIL nodeb_w1: got valid=%b word=%h required 1/1234", d1_valid, d1_word);
            n_fail++;
        end
        n_tests++;
        v = 16'hABCD;
        for (int i = 15; i >= 0; i--) strobe(v[i]);
        // Handshake while full, with an accepted bit in the same cycle
        word_ready = 1'b1;
        strobe(1'b1);
        word_ready = 1'b0;
        if (d1_word !== 16'hABCD || d1_valid !== 1'b1 || d1_ovf !== 1'b0) begin
            $display("FAIL nodeb_full_xfer: got word=%h valid=%b ovf=%b required ABCD/1/0", d1_word, d1_valid, d1_ovf);
            n_fail++;
        end
        n_tests++;
        for (int i = 0; i < 15; i++) strobe(1'b0);
        word_ready = 1'b1;
        idle(1);
        if (d1_word !== 16'h8000 || d1_valid !== 1'b1 || d1_ovf !== 1'b0) begin
            $display("FAIL nodeb_msb: got word=%h valid=%b ovf=%b required 8000/1/0", d1_word, d1_valid, d1_ovf);
            n_fail++;
        end
        n_tests++;
    endtask

    initial begin
        rst        = 1'b1;
        bit_valid  = 1'b0;
        chaos_bit  = 1'b0;
        word_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_alternating();
        test_discard();
        test_overflow();
        test_gaps();
        test_mid_reset();
        test_no_debias();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
